branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters and a saturating mispredict counter.
// Define BP_BYPASS_EN to let a lookup see an update to the same index in the same cycle.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        u_valid,
  input  logic [31:0] u_pc,
  input  logic        u_taken,
  input  logic [31:0] u_target,
  input  logic        u_mispred,
  output logic [15:0] miss_count
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = 30 - IW;

  logic          valid_q  [ENTRIES];
  logic [1:0]    ctr_q    [ENTRIES];
  logic [TW-1:0] tag_q    [ENTRIES];
  logic [31:0]   target_q [ENTRIES];

  logic        pred_valid_q, pred_valid_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;
  logic [15:0] miss_count_q, miss_count_d;

  logic [IW-1:0] f_idx_c, u_idx_c;
  logic [TW-1:0] f_tag_c, u_tag_c;
  logic          u_hit_c;

  logic [TW-1:0] upd_tag_c;
  logic [31:0]   upd_target_c;
  logic [1:0]    upd_ctr_c;

  logic          lk_valid_c;
  logic [TW-1:0] lk_tag_c;
  logic [31:0]   lk_target_c;
  logic [1:0]    lk_ctr_c;
  logic          lk_taken_c;

  // Word-aligned PCs: the two low bits never reach the table.
  logic unused_pc_bits_c;
  assign unused_pc_bits_c = ^{f_pc[1:0], u_pc[1:0]};

  assign f_idx_c = f_pc[2 +: IW];
  assign f_tag_c = f_pc[31 -: TW];
  assign u_idx_c = u_pc[2 +: IW];
  assign u_tag_c = u_pc[31 -: TW];
  assign u_hit_c = valid_q[u_idx_c] && (tag_q[u_idx_c] == u_tag_c);

  // Entry contents after the resolved-branch update (allocate on miss, train on hit).
  always_comb begin
    upd_tag_c    = u_tag_c;
    upd_target_c = u_target;
    upd_ctr_c    = u_taken ? 2'b10 : 2'b01;
    if (u_hit_c) begin
      upd_target_c = u_taken ? u_target : target_q[u_idx_c];
      if (u_taken) begin
        upd_ctr_c = (ctr_q[u_idx_c] == 2'b11) ? 2'b11 : ctr_q[u_idx_c] + 2'b01;
      end else begin
        upd_ctr_c = (ctr_q[u_idx_c] == 2'b00) ? 2'b00 : ctr_q[u_idx_c] - 2'b01;
      end
    end
  end

  // Entry seen by the fetch lookup.
  always_comb begin
    lk_valid_c  = valid_q[f_idx_c];
    lk_tag_c    = tag_q[f_idx_c];
    lk_target_c = target_q[f_idx_c];
    lk_ctr_c    = ctr_q[f_idx_c];
`ifdef BP_BYPASS_EN
    if (u_valid && (u_idx_c == f_idx_c)) begin
      lk_valid_c  = 1'b1;
      lk_tag_c    = upd_tag_c;
      lk_target_c = upd_target_c;
      lk_ctr_c    = upd_ctr_c;
    end
`endif
    lk_taken_c = lk_valid_c && (lk_tag_c == f_tag_c) && lk_ctr_c[1];
  end

  // Next values of the registered prediction and the mispredict counter.
  always_comb begin
    pred_valid_d  = f_valid;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    miss_count_d  = miss_count_q;
    if (f_valid) begin
      pred_taken_d  = lk_taken_c;
      pred_target_d = lk_taken_c ? lk_target_c : f_pc + 32'd4;
    end
    if (u_valid && u_mispred && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'h0;
      miss_count_q  <= 16'h0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[IW'(i)] <= 1'b0;
        ctr_q[IW'(i)]   <= 2'b01;
      end
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      miss_count_q  <= miss_count_d;
      if (u_valid) begin
        valid_q[u_idx_c] <= 1'b1;
        ctr_q[u_idx_c]   <= upd_ctr_c;
      end
    end
  end

  // Tags and targets are qualified by the valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && u_valid) begin
      tag_q[u_idx_c]    <= upd_tag_c;
      target_q[u_idx_c] <= upd_target_c;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign miss_count  = miss_count_q;

endmodule
